// File: rtl/c1541_sd_arbiter.sv
// Round-robin arbiter sharing one SD block-device request channel between drive track loaders.
// Optional ISSUE watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module c1541_sd_arbiter #(
   parameter int NUM_DRIVES     = 2,
   parameter int DW             = 2,
   parameter int TIMEOUT_CYCLES = 2**24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [32*NUM_DRIVES-1:0] drv_lba,
   input  logic [6*NUM_DRIVES-1:0]  drv_blk_cnt,
   input  logic [NUM_DRIVES-1:0]    drv_rd,
   input  logic [NUM_DRIVES-1:0]    drv_wr,
   output logic [NUM_DRIVES-1:0]    drv_ack,
   output logic [31:0]              sd_lba,
   output logic [5:0]               sd_blk_cnt,
   output logic                     sd_rd,
   output logic                     sd_wr,
   input  logic                     sd_ack,
   output logic [DW-1:0]            sd_drive,
   output logic                     busy,
   output logic                     err_timeout
);

   typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

   state_t                  state, state_next;
   logic [DW-1:0]           last_grant, last_grant_next;
   logic [DW-1:0]           grant, sd_drive_next;
   logic                    any_req;
   logic [NUM_DRIVES-1:0]   req;
   logic                    sel_rd, sel_wr;
   logic [31:0]             sel_lba, sd_lba_next;
   logic [5:0]              sel_blk_cnt, sd_blk_cnt_next;
   logic                    sd_rd_next, sd_wr_next, busy_next;
   logic                    timeout_hit;

   generate
      if (NUM_DRIVES < 1 || NUM_DRIVES > 4 || (2**DW) < NUM_DRIVES || TIMEOUT_CYCLES < 1) begin : g_bad_params
         $error("c1541_sd_arbiter: illegal NUM_DRIVES/DW/TIMEOUT_CYCLES combination");
      end
   endgenerate

   assign req = drv_rd | drv_wr;

   // Scan starts one past the previous winner, so a drive that just finished is considered last.
   always_comb begin
      grant       = '0;
      any_req     = 1'b0;
      sel_rd      = 1'b0;
      sel_wr      = 1'b0;
      sel_lba     = '0;
      sel_blk_cnt = '0;
      for (int k = 1; k <= NUM_DRIVES; k++) begin
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (!any_req && req[i] && ((int'(last_grant) + k) % NUM_DRIVES) == i) begin
               grant   = DW'(i);
               any_req = 1'b1;
            end
         end
      end
      for (int i = 0; i < NUM_DRIVES; i++) begin
         if (grant == DW'(i)) begin
            sel_rd      = drv_rd[i];
            sel_wr      = drv_wr[i];
            sel_lba     = drv_lba[32*i +: 32];
            sel_blk_cnt = drv_blk_cnt[6*i +: 6];
         end
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      sd_drive_next   = sd_drive;
      sd_lba_next     = sd_lba;
      sd_blk_cnt_next = sd_blk_cnt;
      sd_rd_next      = sd_rd;
      sd_wr_next      = sd_wr;
      busy_next       = busy;
      case (state)
         IDLE: begin
            if (any_req) begin
               sd_drive_next   = grant;
               sd_lba_next     = sel_lba;
               sd_blk_cnt_next = sel_blk_cnt;
               sd_rd_next      = sel_rd;
               sd_wr_next      = ~sel_rd & sel_wr;
               busy_next       = 1'b1;
               last_grant_next = grant;
               state_next      = ISSUE;
            end
         end
         ISSUE: begin
            if (sd_ack) begin
               sd_rd_next = 1'b0;
               sd_wr_next = 1'b0;
               state_next = XFER;
            end else if (timeout_hit) begin
               sd_rd_next = 1'b0;
               sd_wr_next = 1'b0;
               state_next = GAP;
            end
         end
         XFER: begin
            if (!sd_ack) begin
               state_next = GAP;
            end
         end
         GAP: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= DW'(NUM_DRIVES - 1);
         sd_drive   <= '0;
         sd_lba     <= '0;
         sd_blk_cnt <= '0;
         sd_rd      <= 1'b0;
         sd_wr      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         sd_drive   <= sd_drive_next;
         sd_lba     <= sd_lba_next;
         sd_blk_cnt <= sd_blk_cnt_next;
         sd_rd      <= sd_rd_next;
         sd_wr      <= sd_wr_next;
         busy       <= busy_next;
      end
   end

   // Ack is routed combinationally so the loader sees its edges in the same cycles as the host.
   always_comb begin
      drv_ack = '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         drv_ack[i] = sd_ack && (state == ISSUE || state == XFER) && (sd_drive == DW'(i));
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] issue_cnt;
   logic          err_timeout_q;

   // Counter sits at zero outside ISSUE, so it effectively reloads on every ISSUE entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt     <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         issue_cnt     <= (state_next == ISSUE && state == ISSUE) ? issue_cnt + CW'(1) : '0;
         err_timeout_q <= timeout_hit;
      end
   end

   assign timeout_hit = (state == ISSUE) && !sd_ack && (issue_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign err_timeout = err_timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_c1541_sd_arbiter.sv
// Directed self-checking bench for c1541_sd_arbiter with two drives.
// Exercises the watchdog path only when SD_ARB_TIMEOUT_EN is defined.
module tb_c1541_sd_arbiter;

   logic        clk;
   logic        reset;
   logic [63:0] drv_lba;
   logic [11:0] drv_blk_cnt;
   logic [1:0]  drv_rd;
   logic [1:0]  drv_wr;
   logic [1:0]  drv_ack;
   logic [31:0] sd_lba;
   logic [5:0]  sd_blk_cnt;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;
   logic [1:0]  sd_drive;
   logic        busy;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   c1541_sd_arbiter #(
      .NUM_DRIVES(2),
      .DW(2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .drv_lba(drv_lba),
      .drv_blk_cnt(drv_blk_cnt),
      .drv_rd(drv_rd),
      .drv_wr(drv_wr),
      .drv_ack(drv_ack),
      .sd_lba(sd_lba),
      .sd_blk_cnt(sd_blk_cnt),
      .sd_rd(sd_rd),
      .sd_wr(sd_wr),
      .sd_ack(sd_ack),
      .sd_drive(sd_drive),
      .busy(busy),
      .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic drv, input logic rd, input logic wr,
                                input logic [31:0] lba, input logic [5:0] blk);
      drv_rd[drv] = rd;
      drv_wr[drv] = wr;
      if (drv) begin
         drv_lba[63:32]     = lba;
         drv_blk_cnt[11:6]  = blk;
      end else begin
         drv_lba[31:0]      = lba;
         drv_blk_cnt[5:0]   = blk;
      end
   endtask

   task automatic doReset();
      reset       = 1'b1;
      sd_ack      = 1'b0;
      drv_rd      = '0;
      drv_wr      = '0;
      drv_lba     = '0;
      drv_blk_cnt = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Host handshake for the drive currently in ISSUE; keep=1 models a loader that re-requests at once.
   task automatic doXfer(input logic drv, input logic keep);
      sd_ack = 1'b1;
      #1;
      checkOutput("xfer_ack_rise", 32'(drv_ack), drv ? 32'h2 : 32'h1);
      step();
      checkOutput("xfer_req_clear", 32'(sd_rd | sd_wr), 32'h0);
      checkOutput("xfer_ack_hold", 32'(drv_ack), drv ? 32'h2 : 32'h1);
      if (!keep) begin
         drv_rd[drv] = 1'b0;
         drv_wr[drv] = 1'b0;
      end
      step();
      sd_ack = 1'b0;
      #1;
      checkOutput("xfer_ack_fall", 32'(drv_ack), 32'h0);
      step();
      step();
   endtask

   initial begin
      doReset();
      checkOutput("rst_sd_rd", 32'(sd_rd), 32'h0);
      checkOutput("rst_sd_wr", 32'(sd_wr), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_err", 32'(err_timeout), 32'h0);
      checkOutput("rst_drv_ack", 32'(drv_ack), 32'h0);
      checkOutput("rst_lba", sd_lba, 32'h0);
      checkOutput("rst_blk", 32'(sd_blk_cnt), 32'h0);
      checkOutput("rst_drive", 32'(sd_drive), 32'h0);

      // Single read from drive 0 with a three-cycle ack
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h15, 6'h14);
      step();
      checkOutput("t1_sd_rd", 32'(sd_rd), 32'h1);
      checkOutput("t1_sd_wr", 32'(sd_wr), 32'h0);
      checkOutput("t1_lba", sd_lba, 32'h15);
      checkOutput("t1_blk", 32'(sd_blk_cnt), 32'h14);
      checkOutput("t1_drive", 32'(sd_drive), 32'h0);
      checkOutput("t1_busy", 32'(busy), 32'h1);
      sd_ack = 1'b1;
      #1;
      checkOutput("t1_ack_c1", 32'(drv_ack), 32'h1);
      step();
      drv_rd[0] = 1'b0;
      checkOutput("t1_rd_clear", 32'(sd_rd), 32'h0);
      checkOutput("t1_ack_c2", 32'(drv_ack), 32'h1);
      step();
      checkOutput("t1_ack_c3", 32'(drv_ack), 32'h1);
      step();
      sd_ack = 1'b0;
      #1;
      checkOutput("t1_ack_low", 32'(drv_ack), 32'h0);
      checkOutput("t1_busy_xfer", 32'(busy), 32'h1);
      step();
      checkOutput("t1_busy_gap", 32'(busy), 32'h1);
      step();
      checkOutput("t1_busy_drop", 32'(busy), 32'h0);
      checkOutput("t1_lba_kept", sd_lba, 32'h15);

      // Simultaneous requests: drive 0 first, then drive 1, then drive 0 again
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 6'h01);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 6'h02);
      step();
      checkOutput("t2_g0_drive", 32'(sd_drive), 32'h0);
      checkOutput("t2_g0_rd", 32'(sd_rd), 32'h1);
      checkOutput("t2_g0_lba", sd_lba, 32'h100);
      doXfer(1'b0, 1'b0);
      step();
      checkOutput("t2_g1_drive", 32'(sd_drive), 32'h1);
      checkOutput("t2_g1_wr", 32'(sd_wr), 32'h1);
      checkOutput("t2_g1_rd", 32'(sd_rd), 32'h0);
      checkOutput("t2_g1_lba", sd_lba, 32'h200);
      checkOutput("t2_g1_blk", 32'(sd_blk_cnt), 32'h2);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h101, 6'h03);
      doXfer(1'b1, 1'b0);
      step();
      checkOutput("t2_g2_drive", 32'(sd_drive), 32'h0);
      checkOutput("t2_g2_lba", sd_lba, 32'h101);
      doXfer(1'b0, 1'b0);

      // Drive 0 streams back-to-back while drive 1 holds a write
      doReset();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 6'h04);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 6'h05);
      step();
      checkOutput("t3_g0", 32'(sd_drive), 32'h0);
      doXfer(1'b0, 1'b1);
      step();
      checkOutput("t3_g1", 32'(sd_drive), 32'h1);
      checkOutput("t3_g1_wr", 32'(sd_wr), 32'h1);
      doXfer(1'b1, 1'b1);
      step();
      checkOutput("t3_g2", 32'(sd_drive), 32'h0);
      doXfer(1'b0, 1'b0);
      step();
      checkOutput("t3_g3", 32'(sd_drive), 32'h1);
      doXfer(1'b1, 1'b0);

      // Spurious ack in IDLE, then rd and wr both high on drive 0
      sd_ack = 1'b1;
      #1;
      checkOutput("t4_spur_ack", 32'(drv_ack), 32'h0);
      step();
      checkOutput("t4_spur_busy", 32'(busy), 32'h0);
      checkOutput("t4_spur_rd", 32'(sd_rd), 32'h0);
      sd_ack = 1'b0;
      step();
      checkOutput("t4_spur_busy2", 32'(busy), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h44, 6'h06);
      step();
      checkOutput("t4_rd_wins", 32'(sd_rd), 32'h1);
      checkOutput("t4_wr_low", 32'(sd_wr), 32'h0);
      checkOutput("t4_drive", 32'(sd_drive), 32'h0);

      // Reset while in XFER with ack still high
      sd_ack = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("t5_sd_rd", 32'(sd_rd), 32'h0);
      checkOutput("t5_sd_wr", 32'(sd_wr), 32'h0);
      checkOutput("t5_busy", 32'(busy), 32'h0);
      checkOutput("t5_drv_ack", 32'(drv_ack), 32'h0);
      sd_ack = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h50, 6'h07);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h51, 6'h08);
      step();
      checkOutput("t5_first_drive", 32'(sd_drive), 32'h0);
      checkOutput("t5_first_lba", sd_lba, 32'h50);
      doXfer(1'b0, 1'b0);
      step();
      checkOutput("t5_second_drive", 32'(sd_drive), 32'h1);
      checkOutput("t5_second_lba", sd_lba, 32'h51);
      doXfer(1'b1, 1'b0);

      // Drive 1 read with no host ack
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h66, 6'h09);
      step();
      checkOutput("t6_issue_rd", 32'(sd_rd), 32'h1);
      checkOutput("t6_issue_drive", 32'(sd_drive), 32'h1);
`ifdef SD_ARB_TIMEOUT_EN
      repeat (15) step();
      checkOutput("t6_rd_held", 32'(sd_rd), 32'h1);
      checkOutput("t6_err_quiet", 32'(err_timeout), 32'h0);
      step();
      checkOutput("t6_rd_abort", 32'(sd_rd), 32'h0);
      checkOutput("t6_err_pulse", 32'(err_timeout), 32'h1);
      checkOutput("t6_busy_gap", 32'(busy), 32'h1);
      checkOutput("t6_no_ack", 32'(drv_ack), 32'h0);
      step();
      checkOutput("t6_err_end", 32'(err_timeout), 32'h0);
      checkOutput("t6_busy_clr", 32'(busy), 32'h0);
      step();
      checkOutput("t6_regrant_rd", 32'(sd_rd), 32'h1);
      checkOutput("t6_regrant_drive", 32'(sd_drive), 32'h1);
      doXfer(1'b1, 1'b0);
`else
      repeat (20) step();
      checkOutput("t6_wait_rd", 32'(sd_rd), 32'h1);
      checkOutput("t6_wait_busy", 32'(busy), 32'h1);
      checkOutput("t6_err_tied", 32'(err_timeout), 32'h0);
      doXfer(1'b1, 1'b0);
`endif
      step();
      checkOutput("end_idle_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/c1541_sd_arbiter.md
Name: c1541_sd_arbiter

Overview:
- Shares one SD block-device request channel between NUM_DRIVES drive track loaders.
- Each loader presents lba, blk_cnt and a level rd/wr request. Each loader clears its request on ack rise and detects completion on ack fall.
- The arbiter grants one loader at a time, round-robin, and forwards its request to the host side. It routes ack back to that loader only and reports which drive owns the transfer.
- Sits in the QNICE/SD clock domain, between the per-drive track loaders and the host SD buffer logic.

Parameters:
- NUM_DRIVES, 2: number of requesting drive loaders, 1..4.
- DW, 2: width of drive index. Must satisfy 2**DW >= NUM_DRIVES.
- TIMEOUT_CYCLES, 2**24: cycles to wait for sd_ack after issue. Used only with SD_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  QNICE/SD clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- drv_lba  in  32*NUM_DRIVES  per-drive start LBA; drive i at [32i+31:32i].
- drv_blk_cnt  in  6*NUM_DRIVES  per-drive block count minus one.
- drv_rd  in  NUM_DRIVES  per-drive read request, level.
- drv_wr  in  NUM_DRIVES  per-drive write request, level.
- drv_ack  out  NUM_DRIVES  per-drive ack; only the granted bit can be high.
- sd_lba  out  32  host LBA.
- sd_blk_cnt  out  6  host block count.
- sd_rd  out  1  host read request.
- sd_wr  out  1  host write request.
- sd_ack  in  1  host ack; high for the duration of the transfer.
- sd_drive  out  DW  index of the granted drive; valid from issue until release.
- busy  out  1  high while any transaction is in flight.
- err_timeout  out  1  one-cycle pulse on watchdog abort; tied 0 when the feature is off.

Behaviour:
- FSM states: IDLE, ISSUE, XFER, GAP.
- Reset values:
  - sd_rd, sd_wr, busy, err_timeout, drv_ack: 0.
  - sd_lba, sd_blk_cnt, sd_drive: 0.
  - last_grant: NUM_DRIVES-1, so drive 0 wins the first arbitration.
  - State: IDLE.
- Reset mid-transaction: everything returns to IDLE/reset values the next cycle. A late sd_ack is ignored.
- Request definition: req[i] = drv_rd[i] | drv_wr[i].
- IDLE, when any req is set:
  - Grant the first set bit scanning from last_grant+1 with wrap modulo NUM_DRIVES.
  - Register sd_drive, sd_lba and sd_blk_cnt from that drive's inputs.
  - Set sd_rd = drv_rd[g] and sd_wr = ~drv_rd[g] & drv_wr[g]; rd wins if both are high.
  - Set busy = 1 and last_grant = g. Go to ISSUE.
  - Latency: request sampled in cycle N gives sd_rd/sd_wr high in cycle N+1.
- ISSUE:
  - Hold sd_rd/sd_wr, sd_lba and sd_blk_cnt stable.
  - When sd_ack = 1: clear sd_rd and sd_wr (registered) and go to XFER.
  - Drive inputs are not re-sampled. A requester dropping its request here does not cancel the host request.
- XFER: when sd_ack = 0, go to GAP.
- GAP: one cycle; clear busy and return to IDLE. This gives the finishing loader time to update its request before re-arbitration.
- drv_ack[i] = sd_ack & (state in {ISSUE, XFER}) & (sd_drive == i). This is combinational, so the loader sees the ack rise and fall in the same cycles as the host.
- sd_ack high in IDLE or GAP: ignored, not forwarded, no state change.
- Fairness:
  - A drive that re-requests immediately after its own transfer is scanned last, behind any other pending drive.
  - A single active requester is re-granted with one GAP cycle plus one IDLE cycle of overhead.
- sd_lba and sd_blk_cnt keep their last values after release; consumers must qualify them with sd_rd/sd_wr.
- NUM_DRIVES = 1: arbitration degenerates to a pass-through with the same latency. sd_drive is always 0.

Optional Feature:
- Macro: SD_ARB_TIMEOUT_EN.
- When defined:
  - A counter loads 0 on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without seeing sd_ack: clear sd_rd/sd_wr, pulse err_timeout for 1 cycle, go to GAP, then IDLE.
  - The granted drive never sees an ack; its own request remains and is re-arbitrated normally.
- When undefined: no counter, err_timeout = 0, ISSUE waits indefinitely.

Test Plan:
1. After reset, raise drv_rd[0] with lba 0x15 and blk_cnt 0x14 in cycle N.
   - Response: sd_rd=1, sd_lba=0x15, sd_blk_cnt=0x14, sd_drive=0 at N+1.
   - sd_ack high 3 cycles: drv_ack[0] follows exactly, drv_ack[1]=0.
   - busy drops 1 cycle after ack falls.
2. drv_rd[0] and drv_wr[1] both raised in the same cycle after reset.
   - Response: drive 0 is served first (sd_rd), then drive 1 (sd_wr=1, sd_drive=1).
   - Drive 0 re-requesting during drive 1's transfer is served next.
3. Drive 1 holds drv_wr while drive 0 streams back-to-back reads.
   - Response: grants alternate 0,1,0; no drive is granted twice in a row while the other waits.
4. drv_rd[0] and drv_wr[0] both high.
   - Response: sd_rd=1, sd_wr=0.
   - Spurious sd_ack pulse while IDLE produces no drv_ack and no state change.
5. reset asserted while in XFER with sd_ack high.
   - Response: next cycle sd_rd=sd_wr=busy=0 and drv_ack all 0.
   - Subsequent arbitration starts at drive 0.
6. With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: drv_rd[1] and no sd_ack.
   - Response: sd_rd drops after 16 ISSUE cycles, err_timeout pulses once, busy clears 1 cycle later.
   - Re-grant to drive 1 follows.
